// File: rtl/tie_wire_pkg.sv
// Shared types and defaults for the TIE wire change queue between core0 and core1.
package tie_wire_pkg;

  localparam int TIE_WIRE_WIDTH = 50;
  localparam int TIE_DEPTH      = 4;
  localparam int TIE_CNT_W      = 8;

  typedef logic [TIE_WIRE_WIDTH-1:0] tie_word_t;

endpackage

// File: rtl/tie_wire_fifo.sv
// Small FIFO with extra-MSB pointers: equal pointers mean empty, differing MSBs with equal low bits mean full.
module tie_wire_fifo
  import tie_wire_pkg::*;
#(
  parameter int WIDTH = TIE_WIRE_WIDTH,
  parameter int DEPTH = TIE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];

  // Callers only assert push/pop when the operation is legal.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[ADDR_W-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[ADDR_W-1:0]];

endmodule

// File: rtl/tie_wire_change_queue.sv
// Detects changes on core0's exported TIE state and queues them for core1's import wire,
// counting any change that arrives while the queue is full and not draining.
module tie_wire_change_queue
  import tie_wire_pkg::*;
#(
  parameter int WIDTH = TIE_WIRE_WIDTH,
  parameter int DEPTH = TIE_DEPTH,
  parameter int CNT_W = TIE_CNT_W
) (
  input  logic                     CLK,
  input  logic                     BReset,
  input  logic [WIDTH-1:0]         status_in,
  output logic [WIDTH-1:0]         control_out,
  output logic                     ctrl_valid,
  input  logic                     ctrl_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  input  logic                     clr_overflow
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] control_out_q, control_out_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic             change_s, push_s, pop_s, drop_s;
  logic             fifo_empty_s, fifo_full_s;
  logic [WIDTH-1:0] head_s;

  tie_wire_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (BReset),
    .push  (push_s),
    .wdata (status_in),
    .pop   (pop_s),
    .rdata (head_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .level (level)
  );

  // A full queue still accepts a change when the same edge frees a slot; there is no empty fall-through.
  always_comb begin
    change_s      = (status_in != prev_q);
    pop_s         = !fifo_empty_s && ctrl_ready;
    push_s        = change_s && (!fifo_full_s || pop_s);
    drop_s        = change_s && fifo_full_s && !pop_s;
    prev_d        = status_in;
    control_out_d = control_out_q;
    overflow_d    = overflow_q;
    drop_count_d  = drop_count_q;
    if (pop_s) begin
      control_out_d = head_s;
    end else begin
      control_out_d = control_out_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
      if (clr_overflow) begin
        drop_count_d = CNT_W'(1);
      end else if (drop_count_q != {CNT_W{1'b1}}) begin
        drop_count_d = drop_count_q + CNT_W'(1);
      end else begin
        drop_count_d = drop_count_q;
      end
    end else if (clr_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end
  end

  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      prev_q        <= '0;
      control_out_q <= '0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      prev_q        <= prev_d;
      control_out_q <= control_out_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign control_out = control_out_q;
  assign ctrl_valid  = !fifo_empty_s;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_tie_wire_change_queue.sv
// Directed bench for tie_wire_change_queue with a queue-based reference of the expected FIFO contents.
module tb_tie_wire_change_queue;

  localparam int WIDTH = 50;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic               CLK;
  logic               BReset;
  logic [WIDTH-1:0]   status_in;
  logic [WIDTH-1:0]   control_out;
  logic               ctrl_valid;
  logic               ctrl_ready;
  logic [LVL_W-1:0]   level;
  logic               overflow;
  logic [CNT_W-1:0]   drop_count;
  logic               clr_overflow;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] m_prev;
  logic [WIDTH-1:0] m_ctrl;
  logic             m_ovf;
  logic [CNT_W-1:0] m_cnt;

  tie_wire_change_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK          (CLK),
    .BReset       (BReset),
    .status_in    (status_in),
    .control_out  (control_out),
    .ctrl_valid   (ctrl_valid),
    .ctrl_ready   (ctrl_ready),
    .level        (level),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clr_overflow (clr_overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_prev = '0;
    m_ctrl = '0;
    m_ovf  = 1'b0;
    m_cnt  = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".control_out"}, 64'(control_out), 64'(m_ctrl));
    chk({tag, ".ctrl_valid"},  64'(ctrl_valid),  64'(sb_q.size() != 0));
    chk({tag, ".level"},       64'(level),       64'(sb_q.size()));
    chk({tag, ".overflow"},    64'(overflow),    64'(m_ovf));
    chk({tag, ".drop_count"},  64'(drop_count),  64'(m_cnt));
  endtask

  // One clock: drive inputs, advance the reference across the edge, compare afterwards.
  task automatic step(input string tag, input logic [WIDTH-1:0] s, input logic rdy, input logic clr);
    logic pop, chg, full;
    status_in    = s;
    ctrl_ready   = rdy;
    clr_overflow = clr;
    pop  = rdy && (sb_q.size() != 0);
    chg  = (s != m_prev);
    full = (sb_q.size() == DEPTH);
    @(posedge CLK);
    #1;
    if (pop) m_ctrl = sb_q.pop_front();
    if (chg && (!full || pop)) sb_q.push_back(s);
    if (chg && full && !pop) begin
      m_ovf = 1'b1;
      if (clr) m_cnt = CNT_W'(1);
      else if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + CNT_W'(1);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = '0;
    end
    m_prev = s;
    check_all(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    BReset       = 1'b1;
    status_in    = '0;
    ctrl_ready   = 1'b0;
    clr_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    BReset = 1'b0;

    // idle zero input: nothing ever queued
    for (int i = 0; i < 10; i++) step("idle", '0, 1'b0, 1'b0);
    chk("idle.level_const", 64'(level), 64'd0);

    // single change with consumer ready: valid after 1 cycle, control_out after 2
    v = 50'h3_0000_0000_00A5;
    step("single.c1", v, 1'b1, 1'b0);
    chk("single.valid_c1", 64'(ctrl_valid), 64'd1);
    chk("single.ctrl_c1", 64'(control_out), 64'd0);
    step("single.c2", v, 1'b1, 1'b0);
    chk("single.ctrl_c2", 64'(control_out), 64'(v));
    chk("single.level_c2", 64'(level), 64'd0);
    step("single.c3", v, 1'b1, 1'b0);
    chk("single.hold_c3", 64'(control_out), 64'(v));

    // six distinct changes with consumer stalled: two drops
    for (int i = 1; i <= 6; i++) step("ovf.fill", WIDTH'(i), 1'b0, 1'b0);
    chk("ovf.level", 64'(level), 64'd4);
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.count", 64'(drop_count), 64'd2);
    for (int i = 1; i <= 4; i++) begin
      step("ovf.drain", WIDTH'(6), 1'b1, 1'b0);
      chk("ovf.drain_value", 64'(control_out), 64'(i));
    end
    step("ovf.empty_ready", WIDTH'(6), 1'b1, 1'b0);
    chk("ovf.empty_hold", 64'(control_out), 64'd4);

    // full queue with simultaneous push and pop for 8 cycles
    for (int i = 20; i < 24; i++) step("full.fill", WIDTH'(i), 1'b0, 1'b0);
    for (int i = 24; i < 32; i++) begin
      step("full.stream", WIDTH'(i), 1'b1, 1'b0);
      chk("full.level", 64'(level), 64'd4);
      chk("full.count", 64'(drop_count), 64'd2);
      chk("full.order", 64'(control_out), 64'(i - 4));
    end

    // clear coinciding with a drop, then clear alone
    step("clr.with_drop", WIDTH'(40), 1'b0, 1'b1);
    chk("clr.drop_flag", 64'(overflow), 64'd1);
    chk("clr.drop_count", 64'(drop_count), 64'd1);
    step("clr.alone", WIDTH'(40), 1'b0, 1'b1);
    chk("clr.alone_flag", 64'(overflow), 64'd0);
    chk("clr.alone_count", 64'(drop_count), 64'd0);
    for (int i = 0; i < 4; i++) step("clr.drain", WIDTH'(40), 1'b1, 1'b0);

    // build level=3 with control_out=7, then async reset mid-cycle
    step("rst.push7", WIDTH'(7), 1'b0, 1'b0);
    step("rst.pop7", WIDTH'(7), 1'b1, 1'b0);
    step("rst.q8", WIDTH'(8), 1'b0, 1'b0);
    step("rst.q9", WIDTH'(9), 1'b0, 1'b0);
    step("rst.q7", WIDTH'(7), 1'b0, 1'b0);
    chk("rst.pre_level", 64'(level), 64'd3);
    chk("rst.pre_ctrl", 64'(control_out), 64'd7);
    #2;
    BReset = 1'b1;
    #1;
    model_reset();
    chk("rst.async_ctrl", 64'(control_out), 64'd0);
    chk("rst.async_valid", 64'(ctrl_valid), 64'd0);
    chk("rst.async_level", 64'(level), 64'd0);
    #2;
    BReset = 1'b0;
    step("rst.after1", WIDTH'(7), 1'b0, 1'b0);
    chk("rst.after_level1", 64'(level), 64'd1);
    step("rst.after2", WIDTH'(7), 1'b0, 1'b0);
    chk("rst.after_level2", 64'(level), 64'd1);
    step("rst.after3", WIDTH'(7), 1'b1, 1'b0);
    chk("rst.after_ctrl", 64'(control_out), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
